// File: rtl/div_result_bcd_pkg.sv
// -----------------------------------------------------------------------------
// div_result_bcd_pkg
//   Shared widths, counter sizing and FSM state encoding for the divider
//   result-to-BCD stage. Only the default widths are supported.
// -----------------------------------------------------------------------------
package div_result_bcd_pkg;

    localparam int QW     = 8;          // quotient width (binary)
    localparam int RW     = 7;          // remainder width (binary), RW <= QW
    localparam int DIGITS = 3;          // BCD digits per result
    localparam int BCD_W  = 4 * DIGITS; // packed BCD width
    localparam int CNT_W  = 3;          // iteration counter width

    // Counter value seen on the edge that performs the final (QW-th) iteration.
    localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

    typedef enum logic [1:0] {
        DR_IDLE    = 2'd0,
        DR_CONV    = 2'd1,
        DR_HOLD    = 2'd2,
        DR_ILLEGAL = 2'd3   // unreachable; decoded back to DR_IDLE
    } dr_state_e;

endpackage

// File: rtl/div_result_bcd_adj3.sv
// -----------------------------------------------------------------------------
// bcd_adj3
//   Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more so
//   the following left shift carries correctly into the next decade.
//   Purely combinational.
// Ports:
//   digit_in   in  4  BCD digit before correction
//   digit_out  out 4  corrected digit
// -----------------------------------------------------------------------------
module bcd_adj3 (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Add-3 correction for digits of 5 and above.
    always_comb begin
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/div_result_bcd.sv
// -----------------------------------------------------------------------------
// div_result_bcd
//   Captures the divider's quotient/remainder on the rising edge of div_valid
//   and converts both to 3-digit packed BCD with a sequential shift-add-3
//   engine (one bit per clock). The result is held under a valid/ack
//   handshake. The divider cannot be stalled, so events arriving while busy
//   are dropped and recorded in a sticky overrun flag.
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high
//   div_valid  in   1   divider result valid; its rising edge is the event
//   quotient   in   8   sampled on the capture edge only
//   remainder  in   7   sampled on the capture edge only
//   out_ack    in   1   consumer accepts result (only while out_valid=1)
//   bcd_quot   out  12  quotient BCD {hundreds,tens,ones}
//   bcd_rem    out  12  remainder BCD {hundreds,tens,ones}
//   out_valid  out  1   bcd_* valid and stable
//   busy       out  1   state is not IDLE
//   overrun    out  1   sticky: a divider result was dropped
// -----------------------------------------------------------------------------
module div_result_bcd
    import div_result_bcd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              div_valid,
    input  logic [QW-1:0]     quotient,
    input  logic [RW-1:0]     remainder,
    input  logic              out_ack,
    output logic [BCD_W-1:0]  bcd_quot,
    output logic [BCD_W-1:0]  bcd_rem,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    dr_state_e          state_r,     state_nxt_s;
    logic [CNT_W-1:0]   cnt_r,       cnt_nxt_s;
    logic [QW-1:0]      bin_q_r,     bin_q_nxt_s;
    logic [QW-1:0]      bin_r_r,     bin_r_nxt_s;
    logic [BCD_W-1:0]   acc_q_r,     acc_q_nxt_s;
    logic [BCD_W-1:0]   acc_r_r,     acc_r_nxt_s;
    logic [BCD_W-1:0]   bcd_quot_r,  bcd_quot_nxt_s;
    logic [BCD_W-1:0]   bcd_rem_r,   bcd_rem_nxt_s;
    logic               out_valid_r, out_valid_nxt_s;
    logic               busy_r,      busy_nxt_s;
    logic               overrun_r,   overrun_nxt_s;
    logic               div_valid_q_r;

    logic               ev_s;
    logic [BCD_W-1:0]   adj_q_s;
    logic [BCD_W-1:0]   adj_r_s;
    logic [BCD_W-1:0]   shift_q_s;
    logic [BCD_W-1:0]   shift_r_s;

    // A result event is the rising edge of div_valid, so a level input
    // produces exactly one event.
    assign ev_s = div_valid & ~div_valid_q_r;

    // Per-digit add-3 correction for both accumulators.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_adj3 u_adj_q (
            .digit_in  (acc_q_r[4*d +: 4]),
            .digit_out (adj_q_s[4*d +: 4])
        );
        bcd_adj3 u_adj_r (
            .digit_in  (acc_r_r[4*d +: 4]),
            .digit_out (adj_r_s[4*d +: 4])
        );
    end

    // {acc,bin} shifted left by one: the binary MSB enters the accumulator LSB.
    assign shift_q_s = {adj_q_s[BCD_W-2:0], bin_q_r[QW-1]};
    assign shift_r_s = {adj_r_s[BCD_W-2:0], bin_r_r[QW-1]};

    // Next-state and datapath decode for the IDLE/CONV/HOLD controller.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        bin_q_nxt_s     = bin_q_r;
        bin_r_nxt_s     = bin_r_r;
        acc_q_nxt_s     = acc_q_r;
        acc_r_nxt_s     = acc_r_r;
        bcd_quot_nxt_s  = bcd_quot_r;
        bcd_rem_nxt_s   = bcd_rem_r;
        out_valid_nxt_s = out_valid_r;
        overrun_nxt_s   = overrun_r;

        case (state_r)
            DR_IDLE: begin
                if (ev_s) begin
                    bin_q_nxt_s = quotient;
                    bin_r_nxt_s = {1'b0, remainder};
                    acc_q_nxt_s = {BCD_W{1'b0}};
                    acc_r_nxt_s = {BCD_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = DR_CONV;
                end else begin
                    state_nxt_s = DR_IDLE;
                end
            end

            DR_CONV: begin
                acc_q_nxt_s = shift_q_s;
                acc_r_nxt_s = shift_r_s;
                bin_q_nxt_s = {bin_q_r[QW-2:0], 1'b0};
                bin_r_nxt_s = {bin_r_r[QW-2:0], 1'b0};
                cnt_nxt_s   = cnt_r + 3'd1;
                if (cnt_r == CNT_LAST) begin
                    // Final iteration: publish the shifted accumulators.
                    bcd_quot_nxt_s  = shift_q_s;
                    bcd_rem_nxt_s   = shift_r_s;
                    out_valid_nxt_s = 1'b1;
                    state_nxt_s     = DR_HOLD;
                end else begin
                    state_nxt_s = DR_CONV;
                end
                if (ev_s) begin
                    overrun_nxt_s = 1'b1;
                end else begin
                    overrun_nxt_s = overrun_r;
                end
            end

            DR_HOLD: begin
                if (out_ack) begin
                    out_valid_nxt_s = 1'b0;
                    if (ev_s) begin
                        // Ack and a new event on the same edge: hand over
                        // directly, nothing is lost.
                        bin_q_nxt_s = quotient;
                        bin_r_nxt_s = {1'b0, remainder};
                        acc_q_nxt_s = {BCD_W{1'b0}};
                        acc_r_nxt_s = {BCD_W{1'b0}};
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = DR_CONV;
                    end else begin
                        state_nxt_s = DR_IDLE;
                    end
                end else if (ev_s) begin
                    overrun_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = DR_HOLD;
                end
            end

            default: begin
                state_nxt_s     = DR_IDLE;
                out_valid_nxt_s = 1'b0;
            end
        endcase

        busy_nxt_s = (state_nxt_s != DR_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= DR_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            bin_q_r       <= {QW{1'b0}};
            bin_r_r       <= {QW{1'b0}};
            acc_q_r       <= {BCD_W{1'b0}};
            acc_r_r       <= {BCD_W{1'b0}};
            bcd_quot_r    <= {BCD_W{1'b0}};
            bcd_rem_r     <= {BCD_W{1'b0}};
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            overrun_r     <= 1'b0;
            div_valid_q_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            bin_q_r       <= bin_q_nxt_s;
            bin_r_r       <= bin_r_nxt_s;
            acc_q_r       <= acc_q_nxt_s;
            acc_r_r       <= acc_r_nxt_s;
            bcd_quot_r    <= bcd_quot_nxt_s;
            bcd_rem_r     <= bcd_rem_nxt_s;
            out_valid_r   <= out_valid_nxt_s;
            busy_r        <= busy_nxt_s;
            overrun_r     <= overrun_nxt_s;
            div_valid_q_r <= div_valid;
        end
    end

    assign bcd_quot  = bcd_quot_r;
    assign bcd_rem   = bcd_rem_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_div_result_bcd.sv
// -----------------------------------------------------------------------------
// tb_div_result_bcd
//   Directed-vector bench for div_result_bcd. Inputs are driven and outputs
//   sampled on the falling clock edge; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_div_result_bcd;

    logic        clk;
    logic        reset;
    logic        div_valid;
    logic [7:0]  quotient;
    logic [6:0]  remainder;
    logic        out_ack;
    logic [11:0] bcd_quot;
    logic [11:0] bcd_rem;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    div_result_bcd dut (
        .clk       (clk),
        .reset     (reset),
        .div_valid (div_valid),
        .quotient  (quotient),
        .remainder (remainder),
        .out_ack   (out_ack),
        .bcd_quot  (bcd_quot),
        .bcd_rem   (bcd_rem),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for out_valid; n counts falling edges since the capture
    // edge was driven. busy must stay high while waiting.
    task automatic wait_out(input int already, input int exp_lat);
        int n;
        n = already;
        while (!out_valid && n < 30) begin
            chk("busy_during_conv", {31'd0, busy}, 32'd1);
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_lat);
    endtask

    // One-cycle div_valid pulse, then check the converted result.
    task automatic run_conv(input logic [7:0] q, input logic [6:0] r,
                            input logic [11:0] exp_q, input logic [11:0] exp_r);
        quotient  = q;
        remainder = r;
        div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        wait_out(1, 9);
        chk("bcd_quot", {20'd0, bcd_quot}, {20'd0, exp_q});
        chk("bcd_rem",  {20'd0, bcd_rem},  {20'd0, exp_r});
        chk("out_valid_set", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        chk("ack_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ack_busy",      {31'd0, busy},      32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        div_valid = 1'b0;
        quotient  = 8'd0;
        remainder = 7'd0;
        out_ack   = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state.
        chk("rst_bcd_quot",  {20'd0, bcd_quot}, 32'd0);
        chk("rst_bcd_rem",   {20'd0, bcd_rem},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_overrun",   {31'd0, overrun},   32'd0);

        // Ack while nothing is valid is ignored.
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        chk("idle_ack_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_ack_busy",  {31'd0, busy},      32'd0);

        // 1: maximum operands.
        run_conv(8'd255, 7'd127, 12'h255, 12'h127);
        do_ack();

        // 2: zeros, then 100/9.
        run_conv(8'd0, 7'd0, 12'h000, 12'h000);
        do_ack();
        run_conv(8'd100, 7'd9, 12'h100, 12'h009);

        // 3: result held stable without ack.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_quot",  {20'd0, bcd_quot},  32'h100);
            chk("hold_rem",   {20'd0, bcd_rem},   32'h009);
        end
        do_ack();
        chk("no_overrun_yet", {31'd0, overrun}, 32'd0);

        // 4: second event at e4 of CONV is dropped and flagged.
        quotient  = 8'd123;
        remainder = 7'd45;
        div_valid = 1'b1;
        @(negedge clk);            // after e0
        div_valid = 1'b0;
        @(negedge clk);            // after e1
        @(negedge clk);            // after e2
        @(negedge clk);            // after e3
        quotient  = 8'd7;
        remainder = 7'd1;
        div_valid = 1'b1;
        @(negedge clk);            // after e4
        div_valid = 1'b0;
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        wait_out(5, 9);
        chk("ovr_bcd_quot", {20'd0, bcd_quot}, 32'h123);
        chk("ovr_bcd_rem",  {20'd0, bcd_rem},  32'h045);
        do_ack();
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);
        repeat (3) @(negedge clk);
        chk("overrun_sticky2", {31'd0, overrun}, 32'd1);
        do_reset();
        chk("overrun_cleared", {31'd0, overrun}, 32'd0);

        // 5: ack and new event on the same edge.
        run_conv(8'd50, 7'd3, 12'h050, 12'h003);
        out_ack   = 1'b1;
        quotient  = 8'd42;
        remainder = 7'd5;
        div_valid = 1'b1;
        @(negedge clk);
        out_ack   = 1'b0;
        div_valid = 1'b0;
        chk("handover_valid",   {31'd0, out_valid}, 32'd0);
        chk("handover_busy",    {31'd0, busy},      32'd1);
        chk("handover_overrun", {31'd0, overrun},   32'd0);
        wait_out(1, 9);
        chk("handover_quot", {20'd0, bcd_quot}, 32'h042);
        chk("handover_rem",  {20'd0, bcd_rem},  32'h005);
        chk("handover_overrun2", {31'd0, overrun}, 32'd0);
        do_ack();

        // 6: reset at e5 of CONV, with div_valid held high across reset.
        quotient  = 8'd200;
        remainder = 7'd100;
        div_valid = 1'b1;
        @(negedge clk);            // after e0
        repeat (4) @(negedge clk); // after e4
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);            // reset sampled at e5
        reset = 1'b0;
        chk("midrst_valid",   {31'd0, out_valid}, 32'd0);
        chk("midrst_busy",    {31'd0, busy},      32'd0);
        chk("midrst_quot",    {20'd0, bcd_quot},  32'd0);
        chk("midrst_rem",     {20'd0, bcd_rem},   32'd0);
        chk("midrst_overrun", {31'd0, overrun},   32'd0);
        @(negedge clk);            // first post-reset edge captures
        wait_out(1, 9);
        chk("level_quot", {20'd0, bcd_quot}, 32'h200);
        chk("level_rem",  {20'd0, bcd_rem},  32'h100);
        do_ack();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("level_single_conv", {31'd0, busy}, 32'd0);
        end
        div_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
